// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//
// Purpose:
//   Shares one WIDTH-bit adder between two requesters. A round-robin arbiter
//   picks one operand pair per cycle. The block registers its sum, carry and
//   winner id in a one-entry result slot, which drains through a valid/ready
//   result port. The block sustains at most one result per cycle.
//
// Handshake semantics (all three ports):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and data stable until that edge. Ready may depend
//   combinationally on valid. Ready never gates valid.
//
// Ports:
//   clk         in   1      clock, all state on rising edge
//   rst_n       in   1      asynchronous active-low reset
//   req0_valid  in   1      requester 0 operand pair valid
//   req0_a/b    in   WIDTH  requester 0 operands
//   req0_ready  out  1      requester 0 pair accepted this cycle
//   req1_valid  in   1      requester 1 operand pair valid
//   req1_a/b    in   WIDTH  requester 1 operands
//   req1_ready  out  1      requester 1 pair accepted this cycle
//   res_valid   out  1      result slot holds an unconsumed result
//   res_sum     out  WIDTH  (a+b) mod 2^WIDTH
//   res_carry   out  1      bit WIDTH of a+b
//   res_id      out  1      requester that produced the result
//   res_ready   in   1      consumer takes the result this cycle
// -----------------------------------------------------------------------------
module adder_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    input  logic             res_ready
);

    // The slot state is exactly the res_valid flag.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             slot_free;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   full_sum;

    // Arbitration: a lone requester always wins. On a tie, the requester
    // that did not win the last accepted transfer wins.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // A draining consumer frees the slot in the same cycle.
    // This allows back-to-back accepts.
    assign slot_free = (state_q == ST_EMPTY) || res_ready;

    // rst_n gates the readies so that nothing appears accepted during reset.
    assign req0_ready = rst_n && slot_free && req0_valid && (grant_id == 1'b0);
    assign req1_ready = rst_n && slot_free && req1_valid && (grant_id == 1'b1);
    assign accept     = req0_ready || req1_ready;

    assign op_a     = grant_id ? req1_a : req0_a;
    assign op_b     = grant_id ? req1_b : req0_b;
    assign full_sum = {1'b0, op_a} + {1'b0, op_b};

    // Next-state logic. The default is to hold everything.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            // Also covers drain+accept on the same edge: the new result replaces the old.
            state_d      = ST_FULL;
            sum_d        = full_sum[WIDTH-1:0];
            carry_d      = full_sum[WIDTH];
            id_d         = grant_id;
            last_grant_d = grant_id;
        end else if ((state_q == ST_FULL) && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // last_grant resets to 1 so that req0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, res_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready, res_valid, res_carry, res_id;
    logic [W-1:0] res_sum;

    always #5 clk = ~clk;

    adder_rr_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .res_ready  (res_ready)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- reference model ----------------
    // One-entry result slot plus the id of the last winner.
    // exp_q records every accepted result in order, as {id, carry, sum}.
    logic         m_valid, m_carry, m_id, m_last;
    logic [W-1:0] m_sum;
    logic         exp_free, exp_win, exp_r0, exp_r1;
    logic [W+1:0] exp_q[$];

    task automatic model_reset();
        m_valid = 1'b0; m_sum = '0; m_carry = 1'b0; m_id = 1'b0; m_last = 1'b1;
        exp_q.delete();
    endtask

    // Expected readies for the current inputs.
    task automatic model_eval();
        exp_free = !m_valid || res_ready;
        if (req0_valid && req1_valid) exp_win = !m_last;
        else                          exp_win = req1_valid;
        exp_r0 = exp_free && req0_valid && !exp_win;
        exp_r1 = exp_free && req1_valid && exp_win;
    endtask

    // Advance the model across the next rising edge, then advance the clock.
    task automatic tick();
        logic [W:0] s;
        if (exp_r0 || exp_r1) begin
            if (exp_r1) s = {1'b0, req1_a} + {1'b0, req1_b};
            else        s = {1'b0, req0_a} + {1'b0, req0_b};
            m_sum   = s[W-1:0];
            m_carry = s[W];
            m_id    = exp_r1;
            m_last  = exp_r1;
            m_valid = 1'b1;
            exp_q.push_back({m_id, m_carry, m_sum});
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h07;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        model_reset();
        #3;
        n_vec++; if (req0_ready !== 1'b0) begin n_miss++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_vec++; if (res_sum !== 8'h00) begin n_miss++; $display("FAIL reset_res_sum got %h want 00", res_sum); end
        n_vec++; if ({res_carry, res_id} !== 2'b00) begin n_miss++; $display("FAIL reset_carry_id got %b want 00", {res_carry, res_id}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample();
        n_vec++; if (req0_ready !== 1'b1) begin n_miss++; $display("FAIL reset_first_accept got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        sample();
        n_vec++; if ({res_valid, res_sum, res_id} !== {1'b1, 8'h0C, 1'b0}) begin
            n_miss++; $display("FAIL reset_first_result got v=%b s=%h id=%b want v=1 s=0c id=0", res_valid, res_sum, res_id);
        end
        tick();
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        sample();
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_miss++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        sample();
        n_vec++; if (res_valid !== 1'b1) begin n_miss++; $display("FAIL single_valid got %b want 1", res_valid); end
        n_vec++; if (res_sum !== 8'h46) begin n_miss++; $display("FAIL single_sum got %h want 46", res_sum); end
        n_vec++; if ({res_carry, res_id} !== 2'b00) begin n_miss++; $display("FAIL single_carry_id got %b want 00", {res_carry, res_id}); end
        tick();
        sample();
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL single_drain got %b want 0", res_valid); end
        n_vec++; if (res_sum !== 8'h46) begin n_miss++; $display("FAIL single_hold_sum got %h want 46", res_sum); end
        tick();
    endtask

    task automatic test_overflow();
        res_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        sample();
        n_vec++; if (req1_ready !== 1'b1) begin n_miss++; $display("FAIL ovf_ready got %b want 1", req1_ready); end
        tick();
        req1_b = 8'hFF;
        sample();
        n_vec++; if ({res_carry, res_sum, res_id} !== {1'b1, 8'h00, 1'b1}) begin
            n_miss++; $display("FAIL ovf_ff01 got c=%b s=%h id=%b want c=1 s=00 id=1", res_carry, res_sum, res_id);
        end
        n_vec++; if (req1_ready !== 1'b1) begin n_miss++; $display("FAIL ovf_b2b_ready got %b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        sample();
        n_vec++; if ({res_valid, res_carry, res_sum} !== {1'b1, 1'b1, 8'hFE}) begin
            n_miss++; $display("FAIL ovf_ffff got v=%b c=%b s=%h want v=1 c=1 s=fe", res_valid, res_carry, res_sum);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic want0;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
        for (int i = 0; i < 6; i++) begin
            sample();
            want0 = (i % 2 == 0);
            n_vec++; if ({req0_ready, req1_ready} !== {want0, !want0}) begin
                n_miss++; $display("FAIL fair_ready[%0d] got %b want %b", i, {req0_ready, req1_ready}, {want0, !want0});
            end
            if (i > 0) begin
                n_vec++; if ({res_valid, res_id} !== {1'b1, want0}) begin
                    n_miss++; $display("FAIL fair_id[%0d] got v=%b id=%b want v=1 id=%b", i, res_valid, res_id, want0);
                end
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        n_vec++; if ({res_valid, res_id, res_sum} !== {1'b1, 1'b1, 8'h30}) begin
            n_miss++; $display("FAIL fair_last got v=%b id=%b s=%h want v=1 id=1 s=30", res_valid, res_id, res_sum);
        end
        tick();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h41;
        sample();
        tick();
        req0_a = 8'h50; req0_b = 8'h51;
        req1_valid = 1'b1; req1_a = 8'h60; req1_b = 8'h61;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin
                n_miss++; $display("FAIL bp_ready[%0d] got %b want 00", i, {req0_ready, req1_ready});
            end
            n_vec++; if ({res_valid, res_sum, res_id} !== {1'b1, 8'h81, 1'b0}) begin
                n_miss++; $display("FAIL bp_stable[%0d] got v=%b s=%h id=%b want v=1 s=81 id=0", i, res_valid, res_sum, res_id);
            end
            tick();
        end
        res_ready = 1'b1;
        sample();
        // req0 won the last transfer, so req1 wins the tie.
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin
            n_miss++; $display("FAIL bp_release got %b want 01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 1'b0;
        sample();
        n_vec++; if ({res_valid, res_sum, res_id} !== {1'b1, 8'hC1, 1'b1}) begin
            n_miss++; $display("FAIL bp_replace got v=%b s=%h id=%b want v=1 s=c1 id=1", res_valid, res_sum, res_id);
        end
        tick();
        req0_valid = 1'b0;
        sample();
        n_vec++; if ({res_sum, res_id} !== {8'hA1, 1'b0}) begin
            n_miss++; $display("FAIL bp_next got s=%h id=%b want s=a1 id=0", res_sum, res_id);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h70; req0_b = 8'h71;
        sample();
        tick();
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_valid got %b want 0", res_valid); end
        n_vec++; if (res_sum !== 8'h00) begin n_miss++; $display("FAIL midrst_sum got %h want 00", res_sum); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04;
        req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h06;
        sample();
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin
            n_miss++; $display("FAIL midrst_grant got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        n_vec++; if ({res_valid, res_id, res_sum} !== {1'b1, 1'b0, 8'h07}) begin
            n_miss++; $display("FAIL midrst_first got v=%b id=%b s=%h want v=1 id=0 s=07", res_valid, res_id, res_sum);
        end
        tick();
    endtask

    function automatic logic [W-1:0] rand_op();
        // Bias towards the extreme values.
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [W+1:0] got, want;
        exp_q.delete();
        if (m_valid) exp_q.push_back({m_id, m_carry, m_sum});
        exp_r0 = 1'b1; exp_r1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            // Requesters keep an offer until it is accepted.
            if (!req0_valid || exp_r0) begin
                req0_valid = ($urandom_range(0, 3) != 0); req0_a = rand_op(); req0_b = rand_op();
            end
            if (!req1_valid || exp_r1) begin
                req1_valid = ($urandom_range(0, 3) != 0); req1_a = rand_op(); req1_b = rand_op();
            end
            res_ready = ($urandom_range(0, 3) != 0);
            sample();
            n_vec++; if ({req0_ready, req1_ready} !== {exp_r0, exp_r1}) begin
                n_miss++; $display("FAIL rnd_ready[%0d] got %b want %b", i, {req0_ready, req1_ready}, {exp_r0, exp_r1});
            end
            n_vec++; if ({res_valid, res_id, res_carry, res_sum} !== {m_valid, m_id, m_carry, m_sum}) begin
                n_miss++; $display("FAIL rnd_res[%0d] got v=%b id=%b c=%b s=%h want v=%b id=%b c=%b s=%h",
                                   i, res_valid, res_id, res_carry, res_sum, m_valid, m_id, m_carry, m_sum);
            end
            if (m_valid && res_ready) begin
                got = {res_id, res_carry, res_sum};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++; $display("FAIL rnd_sb_empty[%0d] got %h want none", i, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin n_miss++; $display("FAIL rnd_sb[%0d] got %h want %h", i, got, want); end
                end
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        sample();
        tick();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
